// File: rtl/dsc_pkg.sv
// rtl/dsc_pkg.sv - shared FSM state type and cycle-counter width for the sequencer
package dsc_pkg;

  localparam int CYC_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_SETTLE,
    S_OUT
  } dsc_state_e;

endpackage

// File: rtl/dsc_cyc_ctr.sv
// rtl/dsc_cyc_ctr.sv - saturating cycle counter, clear has priority over enable
module dsc_cyc_ctr
  import dsc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CYC_W-1:0] o_count
);

  logic [CYC_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != {CYC_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/dsc_mul_seq.sv
// rtl/dsc_mul_seq.sv - sequencer driving an external four-operand multiplier with timeout
module dsc_mul_seq
  import dsc_pkg::*;
#(
  parameter int NUM_BITS    = 6,
  parameter int TIMEOUT_CYC = 2**(4*NUM_BITS) + 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_BITS-1:0]   in_a,
  input  logic [NUM_BITS-1:0]   in_b,
  input  logic [NUM_BITS-1:0]   in_c,
  input  logic [NUM_BITS-1:0]   in_d,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*NUM_BITS-1:0] out_z,
  output logic [CYC_W-1:0]      out_cycles,
  output logic                  out_err,
  output logic                  mul_rst,
  output logic                  mul_en,
  output logic [NUM_BITS-1:0]   mul_a,
  output logic [NUM_BITS-1:0]   mul_b,
  output logic [NUM_BITS-1:0]   mul_c,
  output logic [NUM_BITS-1:0]   mul_d,
  input  logic [4*NUM_BITS-1:0] mul_z,
  input  logic                  mul_ov,
  output logic                  busy
);

  localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(TIMEOUT_CYC - 1);

  dsc_state_e          r_state;
  dsc_state_e          w_state_nxt;
  logic [NUM_BITS-1:0] r_a, r_b, r_c, r_d;
  logic [CYC_W-1:0]    w_count;
  logic                w_accept;
  logic                w_any_zero;
  logic                w_timeout;

  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_any_zero = (in_a == '0) || (in_b == '0) || (in_c == '0) || (in_d == '0);
  // Timeout fires during the last allowed RUN cycle, so RUN lasts exactly TIMEOUT_CYC cycles.
  assign w_timeout  = (w_count >= TO_LAST);

  dsc_cyc_ctr u_ctr (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_accept),
    .i_en    (r_state == S_RUN),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = w_any_zero ? S_OUT : S_LOAD;
      S_LOAD:   w_state_nxt = S_RUN;
      S_RUN: begin
        if (mul_ov)         w_state_nxt = S_SETTLE;
        else if (w_timeout) w_state_nxt = S_OUT;
      end
      S_SETTLE: w_state_nxt = S_OUT;
      S_OUT:    if (out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Result registers change only on entry to OUT, so they stay stable while OUT waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_d        <= '0;
      out_z      <= '0;
      out_cycles <= '0;
      out_err    <= 1'b0;
    end else if (w_accept) begin
      r_a <= in_a;
      r_b <= in_b;
      r_c <= in_c;
      r_d <= in_d;
      if (w_any_zero) begin
        out_z      <= '0;
        out_cycles <= '0;
        out_err    <= 1'b0;
      end
    end else if (r_state == S_SETTLE) begin
      out_z      <= mul_z;
      out_cycles <= w_count;
      out_err    <= 1'b0;
    end else if ((r_state == S_RUN) && !mul_ov && w_timeout) begin
      out_z      <= '0;
      out_cycles <= w_count + 1'b1;
      out_err    <= 1'b1;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign busy      = (r_state != S_IDLE);
  assign mul_en    = (r_state == S_RUN);
  assign mul_rst   = !((r_state == S_RUN) || (r_state == S_SETTLE));
  assign mul_a     = r_a;
  assign mul_b     = r_b;
  assign mul_c     = r_c;
  assign mul_d     = r_d;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// tb/tb_dsc_mul_seq.sv - directed self-checking bench with a behavioural 4-cycle multiplier
module tb_dsc_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, in_ready;
  logic [5:0]  in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [23:0] out_z;
  logic [31:0] out_cycles;
  logic        out_err;
  logic        mul_rst, mul_en;
  logic [5:0]  mul_a, mul_b, mul_c, mul_d;
  logic [23:0] m_z;
  logic        m_ov;
  logic        busy;
  int          m_cnt;

  logic        t_in_valid = 1'b0, t_in_ready;
  logic [5:0]  t_a = '0;
  logic        t_out_valid;
  logic [23:0] t_out_z;
  logic [31:0] t_out_cycles;
  logic        t_out_err;
  logic        t_mul_rst, t_mul_en;
  logic [5:0]  t_mul_a, t_mul_b, t_mul_c, t_mul_d;
  logic        t_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dsc_mul_seq u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_cycles(out_cycles), .out_err(out_err),
    .mul_rst(mul_rst), .mul_en(mul_en),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_d(mul_d),
    .mul_z(m_z), .mul_ov(m_ov), .busy(busy)
  );

  dsc_mul_seq #(.NUM_BITS(6), .TIMEOUT_CYC(100)) u_to (
    .clk(clk), .rst(rst),
    .in_valid(t_in_valid), .in_ready(t_in_ready),
    .in_a(t_a), .in_b(t_a), .in_c(t_a), .in_d(t_a),
    .out_valid(t_out_valid), .out_ready(1'b1),
    .out_z(t_out_z), .out_cycles(t_out_cycles), .out_err(t_out_err),
    .mul_rst(t_mul_rst), .mul_en(t_mul_en),
    .mul_a(t_mul_a), .mul_b(t_mul_b), .mul_c(t_mul_c), .mul_d(t_mul_d),
    .mul_z(24'd0), .mul_ov(1'b0), .busy(t_busy)
  );

  // External multiplier: result and overflow flag raised after the 4th enabled cycle, held until reset.
  always @(posedge clk) begin
    if (mul_rst) begin
      m_cnt <= 0;
      m_ov  <= 1'b0;
      m_z   <= '0;
    end else if (mul_en) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 3) begin
        m_ov <= 1'b1;
        m_z  <= 24'(mul_a) * 24'(mul_b) * 24'(mul_c) * 24'(mul_d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c, input logic [5:0] d);
    int k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    check("send_in_ready", {63'd0, in_ready}, 64'd1);
    in_a = a; in_b = b; in_c = c; in_d = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int k = 0;
    while (!out_valid && k < 50) begin
      tick();
      k++;
    end
    check(tag, {63'd0, out_valid}, 64'd1);
  endtask

  initial begin
    int n;

    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready",   {63'd0, in_ready},  64'd1);
    check("rst_out_valid",  {63'd0, out_valid}, 64'd0);
    check("rst_busy",       {63'd0, busy},      64'd0);
    check("rst_mul_rst",    {63'd0, mul_rst},   64'd1);
    check("rst_mul_en",     {63'd0, mul_en},    64'd0);
    check("rst_out_z",      {40'd0, out_z},     64'd0);
    check("rst_out_cycles", {32'd0, out_cycles},64'd0);
    check("rst_out_err",    {63'd0, out_err},   64'd0);
    check("rst_mul_a",      {58'd0, mul_a},     64'd0);
    tick();
    check("rst_in_ready_edge", {63'd0, in_ready}, 64'd1);

    // 15^4 with the 4-cycle multiplier: five RUN cycles (ov seen in the 5th)
    send(6'd15, 6'd15, 6'd15, 6'd15);
    check("load_busy",     {63'd0, busy},     64'd1);
    check("load_in_ready", {63'd0, in_ready}, 64'd0);
    check("load_mul_rst",  {63'd0, mul_rst},  64'd1);
    check("load_mul_en",   {63'd0, mul_en},   64'd0);
    tick();
    check("run_mul_rst", {63'd0, mul_rst}, 64'd0);
    check("run_mul_en",  {63'd0, mul_en},  64'd1);
    check("run_mul_a",   {58'd0, mul_a},   64'd15);
    check("run_mul_d",   {58'd0, mul_d},   64'd15);
    wait_out("j15_out_valid");
    check("j15_out_z",      {40'd0, out_z},      64'd50625);
    check("j15_out_err",    {63'd0, out_err},    64'd0);
    check("j15_out_cycles", {32'd0, out_cycles}, 64'd5);
    check("j15_out_mul_en", {63'd0, mul_en},     64'd0);
    check("j15_out_mul_rst",{63'd0, mul_rst},    64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("j15_after_valid", {63'd0, out_valid}, 64'd0);
    check("j15_after_ready", {63'd0, in_ready},  64'd1);

    // 63^4 with out_ready held low for 10 cycles
    send(6'd63, 6'd63, 6'd63, 6'd63);
    wait_out("j63_out_valid");
    check("j63_out_err", {63'd0, out_err}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("j63_hold_valid",    {63'd0, out_valid}, 64'd1);
      check("j63_hold_z",        {40'd0, out_z},     64'd15752961);
      check("j63_hold_in_ready", {63'd0, in_ready},  64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Zero operand bypasses the multiplier entirely
    send(6'd0, 6'd7, 6'd9, 6'd3);
    check("zero_out_valid",  {63'd0, out_valid},  64'd1);
    check("zero_out_z",      {40'd0, out_z},      64'd0);
    check("zero_out_cycles", {32'd0, out_cycles}, 64'd0);
    check("zero_out_err",    {63'd0, out_err},    64'd0);
    check("zero_mul_en",     {63'd0, mul_en},     64'd0);
    check("zero_mul_rst",    {63'd0, mul_rst},    64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("zero_idle_mul_en", {63'd0, mul_en},   64'd0);
    check("zero_idle_ready",  {63'd0, in_ready}, 64'd1);

    // Asynchronous reset in RUN cycle 5 discards the job
    send(6'd2, 6'd2, 6'd2, 6'd2);
    tick();
    tick(); tick(); tick(); tick();
    check("mid_run_mul_en", {63'd0, mul_en}, 64'd1);
    rst = 1'b1;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_mul_rst",   {63'd0, mul_rst},   64'd1);
    check("arst_busy",      {63'd0, busy},      64'd0);
    check("arst_in_ready",  {63'd0, in_ready},  64'd1);
    #1;
    rst = 1'b0;
    tick();
    check("arst_out_valid_after", {63'd0, out_valid}, 64'd0);
    send(6'd2, 6'd2, 6'd2, 6'd2);
    wait_out("j2_out_valid");
    check("j2_out_z",      {40'd0, out_z},      64'd16);
    check("j2_out_err",    {63'd0, out_err},    64'd0);
    check("j2_out_cycles", {32'd0, out_cycles}, 64'd5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Timeout instance: mul_ov tied low, TIMEOUT_CYC=100
    check("to_in_ready", {63'd0, t_in_ready}, 64'd1);
    t_a = 6'd5;
    t_in_valid = 1'b1;
    tick();
    t_in_valid = 1'b0;
    tick();
    check("to_run_mul_en", {63'd0, t_mul_en}, 64'd1);
    n = 0;
    while (!t_out_valid && n < 200) begin
      tick();
      n++;
    end
    check("to_out_valid",  {63'd0, t_out_valid},  64'd1);
    check("to_run_cycles", 64'(n),                64'd100);
    check("to_out_err",    {63'd0, t_out_err},    64'd1);
    check("to_out_z",      {40'd0, t_out_z},      64'd0);
    check("to_out_cycles", {32'd0, t_out_cycles}, 64'd100);
    check("to_out_mul_en", {63'd0, t_mul_en},     64'd0);
    tick();
    check("to_back_idle", {63'd0, t_in_ready}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
